// File: rtl/map_select_ctrl_pkg.sv
// Shared constants and state type for the map selector.
package map_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_CYCLE  = 1'b1;

    localparam int BTN_NEXT = 0;
    localparam int BTN_PREV = 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sel_state_t;

endpackage

// File: rtl/map_select_ctrl_if.sv
// Map-change handshake between the selector (master) and the draw FSM (slave).
interface map_select_ctrl_if #(
    parameter int SEL_W = 2
);
    logic             change_valid;
    logic             change_ready;
    logic [SEL_W-1:0] req_map;

    modport master (output change_valid, output req_map, input change_ready);
    modport slave  (input change_valid, input req_map, output change_ready);
endinterface

// File: rtl/map_select_ctrl_debounce.sv
// Per-button debouncer: accepts a new level after DEBOUNCE_CYCLES identical samples
// and emits a one-cycle rise pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (raw != level_q) begin
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = raw;
                rise_d  = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous reset;
    // next-state values come only from the always_comb above.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/map_select_ctrl.sv
// Debounced map selector: turns button presses into map-change requests and
// commits them through a valid/ready handshake with the draw FSM.
module map_select_ctrl
    import map_sel_pkg::*;
#(
    parameter int NUM_MAPS        = 4,
    parameter int SEL_W           = $clog2(NUM_MAPS),
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_MAPS-1:0] btn,
    input  logic                mode,
    map_select_ctrl_if.master   chg,
    output logic [SEL_W-1:0]    map_sel,
    output logic                press_drop
);

    logic [NUM_MAPS-1:0] level_w;
    logic [NUM_MAPS-1:0] rise_w;

    for (genvar g = 0; g < NUM_MAPS; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (btn[g]),
            .level(level_w[g]),
            .rise (rise_w[g])
        );
    end

    sel_state_t       state_q, state_d;
    logic [SEL_W-1:0] req_map_q, req_map_d;
    logic [SEL_W-1:0] map_sel_q, map_sel_d;
    logic             drop_q, drop_d;
    logic [SEL_W-1:0] cand;
    logic             cand_vld;

    // Wrap explicitly so non-power-of-two map counts never reach unused indices.
    always_comb begin
        cand     = map_sel_q;
        cand_vld = 1'b0;
        if (mode == MODE_DIRECT) begin
            for (int i = NUM_MAPS - 1; i >= 0; i--) begin
                if (rise_w[i]) begin
                    cand     = SEL_W'(i);
                    cand_vld = 1'b1;
                end
            end
        end else if (rise_w[BTN_NEXT] && !rise_w[BTN_PREV]) begin
            cand     = (map_sel_q == SEL_W'(NUM_MAPS - 1)) ? '0 : map_sel_q + 1'b1;
            cand_vld = 1'b1;
        end else if (rise_w[BTN_PREV] && !rise_w[BTN_NEXT]) begin
            cand     = (map_sel_q == '0) ? SEL_W'(NUM_MAPS - 1) : map_sel_q - 1'b1;
            cand_vld = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_map_d = req_map_q;
        map_sel_d = map_sel_q;
        drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_vld && cand != map_sel_q) begin
                    req_map_d = cand;
                    state_d   = REQ;
                end
            end
            REQ: begin
                drop_d = |rise_w;
                if (chg.change_ready) begin
                    map_sel_d = req_map_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_map_q <= '0;
            map_sel_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_map_q <= req_map_d;
            map_sel_q <= map_sel_d;
            drop_q    <= drop_d;
        end
    end

    assign chg.change_valid = (state_q == REQ);
    assign chg.req_map      = req_map_q;
    assign map_sel          = map_sel_q;
    assign press_drop       = drop_q;

endmodule
